fifo_rd_ctrl: RTL

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/async_fifo_pkg.sv | 37 +++
 rtl/sync2.sv | 42 ++++
 rtl/fifo_rd_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : async_fifo_pkg                                         |
// | Description : Shared types and Gray/binary pointer conversions for   |
// |               the asynchronous FIFO read/write controllers.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package async_fifo_pkg;

   // Conversions work on a 32-bit container. Callers zero-extend
   // narrower pointers in and size-cast the result back down. Leading
   // zeros do not disturb either conversion.
   localparam int PTR_MAX_W = 32;

   typedef logic [PTR_MAX_W-1:0] ptr_word_t;

   // Read-side output stage: IDLE has no word at o_data, HOLD has one.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } rd_state_e;

   function automatic ptr_word_t bin2gray(input ptr_word_t bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic ptr_word_t gray2bin(input ptr_word_t gray);
      ptr_word_t bin;
      bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sync2                                                  |
// | Description : Two-flop synchronizer, parameterized width, with       |
// |               asynchronous active-low clear.                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sync2 #(
   parameter int Width = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [Width-1:0] i_d,
   output logic [Width-1:0] o_q
);

   logic [Width-1:0] meta_q;
   logic [Width-1:0] meta_d;
   logic [Width-1:0] sync_q;
   logic [Width-1:0] sync_d;

   // Shift the input through two stages.
   always_comb begin
      meta_d = i_d;
      sync_d = meta_q;
   end

   // Synchronizer flops. The clear is asynchronous.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign o_q = sync_q;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fifo_rd_ctrl                                           |
// | Description : Read-side controller of an asynchronous FIFO. It       |
// |               synchronizes the write pointer, issues RAM reads and   |
// |               presents one word at a time to a valid/ready consumer. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fifo_rd_ctrl
   import async_fifo_pkg::*;
#(
   parameter int Depth          = 8,
   parameter int Width          = 4,
   parameter int PtrWidth       = $clog2(Depth),
   parameter int AlmostEmptyThr = 2
) (
   input  logic                clk_rd,
   input  logic                rst_n,
   input  logic [PtrWidth:0]   i_wr_ptr_gray,
   output logic [PtrWidth:0]   o_rd_ptr_gray,
   output logic                o_ram_rd_en,
   output logic [PtrWidth-1:0] o_ram_rd_addr,
   input  logic [Width-1:0]    i_ram_rd_data,
   output logic [Width-1:0]    o_data,
   output logic                o_valid,
   input  logic                i_ready,
   output logic                o_empty,
   output logic                o_almost_empty,
   output logic [PtrWidth:0]   o_count
);

   localparam int              PW     = PtrWidth + 1;
   localparam logic [PtrWidth:0] AE_THR = PW'(AlmostEmptyThr);

   logic              rst_sync_n;
   logic [PtrWidth:0] wr_gray_sync;
   logic [PtrWidth:0] wr_bin;
   logic [PtrWidth:0] rd_bin_q;
   logic [PtrWidth:0] rd_bin_d;
   logic [PtrWidth:0] rd_gray_q;
   logic [PtrWidth:0] rd_gray_d;
   logic [PtrWidth:0] count;
   logic              empty;
   logic              fetch;
   logic              valid;
   rd_state_e         state_q;
   rd_state_e         state_d;

   // Reset asserts immediately and releases two clk_rd edges later.
   sync2 #(
      .Width (1)
   ) u_rst_sync (
      .clk   (clk_rd),
      .rst_n (rst_n),
      .i_d   (1'b1),
      .o_q   (rst_sync_n)
   );

   // Gray-coded write pointer crossing into the read domain.
   sync2 #(
      .Width (PW)
   ) u_wr_sync (
      .clk   (clk_rd),
      .rst_n (rst_sync_n),
      .i_d   (i_wr_ptr_gray),
      .o_q   (wr_gray_sync)
   );

   // Occupancy and flags from the synchronized write pointer. The
   // subtraction wraps naturally at PW bits, so a full RAM reads Depth.
   always_comb begin
      wr_bin = PW'(gray2bin(PTR_MAX_W'(wr_gray_sync)));
      count  = wr_bin - rd_bin_q;
      empty  = (rd_bin_q == wr_bin);
   end

   // A RAM read is issued when a word is available and the output slot
   // is free or is being emptied this cycle.
   always_comb begin
      fetch     = !empty && (!valid || i_ready);
      rd_bin_d  = rd_bin_q + {{PtrWidth{1'b0}}, fetch};
      rd_gray_d = PW'(bin2gray(PTR_MAX_W'(rd_bin_d)));
   end

   // Read pointer in binary, with its Gray copy kept in step for export.
   always_ff @(posedge clk_rd or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         rd_bin_q  <= '0;
         rd_gray_q <= '0;
      end else begin
         rd_bin_q  <= rd_bin_d;
         rd_gray_q <= rd_gray_d;
      end
   end

   // Output-stage state register.
   always_ff @(posedge clk_rd or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Output-stage next state: a fetch always leaves a word at o_data.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (fetch) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (i_ready && !fetch) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output-stage decode.
   always_comb begin
      valid = (state_q == ST_HOLD);
   end

   // The RAM holds its read data while the strobe is low, so the word is
   // passed straight through rather than stored here.
   assign o_data         = i_ram_rd_data;
   assign o_valid        = valid;
   assign o_ram_rd_en    = fetch;
   assign o_ram_rd_addr  = rd_bin_q[PtrWidth-1:0];
   assign o_rd_ptr_gray  = rd_gray_q;
   assign o_empty        = empty;
   assign o_count        = count;
   assign o_almost_empty = (count <= AE_THR);

endmodule
`default_nettype wire
